// File: rtl/bcd_display_driver.sv
// Sequential double-dabble BCD converter feeding a 6-digit multiplexed 7-segment scanner.
// Optional SIGNED_DISPLAY_EN: two's-complement input, magnitude display with a minus on digit5.
module bcd_display_driver #(
  parameter int SCAN_DIV       = 1000,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        RST,
  input  logic [15:0] value_in,
  input  logic        value_valid,
  output logic        busy,
  output logic [19:0] bcd_out,
  output logic        bcd_valid,
  output logic        bcd_neg,
  output logic [6:0]  seg_out,
  output logic [5:0]  an_out
);

  // state | meaning
  // IDLE  | waiting for a start edge or a leftover pending request
  // SHIFT | one double-dabble iteration per clock, 16 in total
  // DONE  | publish result; chain straight into a pending request
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  state_t      state_q, state_d;
  logic [35:0] scratch_q, scratch_d;
  logic [4:0]  iter_q, iter_d;
  logic        pending_q, pending_d;
  logic        vv_q;
  logic [19:0] bcd_q;
  logic        bcd_valid_q;
  logic        start, load, shift_en, done;
  logic [15:0] cap_mag;

  assign start = value_valid & ~vv_q;

  function automatic logic [35:0] dabble(input logic [35:0] s);
    logic [35:0] t;
    t = s;
    for (int i = 0; i < 5; i++) begin
      if (t[16+4*i +: 4] >= 4'd5) t[16+4*i +: 4] = t[16+4*i +: 4] + 4'd3;
    end
    return {t[34:0], 1'b0};
  endfunction

`ifdef SIGNED_DISPLAY_EN
  logic cap_neg, neg_cap_q, bcd_neg_q;
  assign cap_neg = value_in[15];
  assign cap_mag = value_in[15] ? (~value_in + 16'd1) : value_in;
  assign bcd_neg = bcd_neg_q;
`else
  assign cap_mag = value_in;
  assign bcd_neg = 1'b0;
`endif

  always_ff @(posedge clk or posedge RST) begin
    if (RST) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start || pending_q) state_d = S_SHIFT;
      S_SHIFT: if (iter_q == 5'd15) state_d = S_DONE;
      S_DONE:  state_d = pending_q ? S_SHIFT : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    load     = 1'b0;
    shift_en = 1'b0;
    done     = 1'b0;
    case (state_q)
      S_IDLE:  load = start | pending_q;
      S_SHIFT: shift_en = 1'b1;
      S_DONE: begin
        done = 1'b1;
        load = pending_q;
      end
      default: ;
    endcase
  end

  assign busy = (state_q != S_IDLE);

  always_comb begin
    scratch_d = scratch_q;
    iter_d    = iter_q;
    pending_d = pending_q;
    if (load) begin
      scratch_d = {20'b0, cap_mag};
      iter_d    = 5'd0;
      pending_d = 1'b0;
    end else begin
      if (shift_en) begin
        scratch_d = dabble(scratch_q);
        iter_d    = iter_q + 5'd1;
      end
      // edges seen while converting collapse into a single request
      if (start && state_q != S_IDLE) pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      scratch_q   <= '0;
      iter_q      <= '0;
      pending_q   <= 1'b0;
      vv_q        <= 1'b0;
      bcd_q       <= '0;
      bcd_valid_q <= 1'b0;
    end else begin
      scratch_q   <= scratch_d;
      iter_q      <= iter_d;
      pending_q   <= pending_d;
      vv_q        <= value_valid;
      bcd_valid_q <= done;
      if (done) bcd_q <= scratch_q[35:16];
    end
  end

`ifdef SIGNED_DISPLAY_EN
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      neg_cap_q <= 1'b0;
      bcd_neg_q <= 1'b0;
    end else begin
      if (load) neg_cap_q <= cap_neg;
      if (done) bcd_neg_q <= neg_cap_q;
    end
  end
`endif

  assign bcd_out   = bcd_q;
  assign bcd_valid = bcd_valid_q;

  // Display scan: prescaler wrap advances the selected digit
  logic [PW-1:0] presc_q, presc_d;
  logic [2:0]    digit_q, digit_d;
  logic          wrap;

  assign wrap = (presc_q == PW'(SCAN_DIV - 1));

  always_comb begin
    presc_d = wrap ? '0 : presc_q + 1'b1;
    digit_d = digit_q;
    if (wrap) digit_d = (digit_q == 3'd5) ? 3'd0 : digit_q + 3'd1;
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      presc_q <= '0;
      digit_q <= '0;
    end else begin
      presc_q <= presc_d;
      digit_q <= digit_d;
    end
  end

  function automatic logic [6:0] seg_enc(input logic [3:0] n);
    case (n)
      4'd0:    return 7'h3F;
      4'd1:    return 7'h06;
      4'd2:    return 7'h5B;
      4'd3:    return 7'h4F;
      4'd4:    return 7'h66;
      4'd5:    return 7'h6D;
      4'd6:    return 7'h7D;
      4'd7:    return 7'h07;
      4'd8:    return 7'h7F;
      4'd9:    return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  logic [2:0] msd;
  logic [3:0] nib;
  logic [6:0] seg_ah;
  logic [5:0] an_ah;

  always_comb begin
    msd = 3'd0;
    for (int i = 1; i < 5; i++) begin
      if (bcd_q[4*i +: 4] != 4'd0) msd = 3'(i);
    end
  end

  always_comb begin
    nib = 4'd0;
    case (digit_q)
      3'd0:    nib = bcd_q[3:0];
      3'd1:    nib = bcd_q[7:4];
      3'd2:    nib = bcd_q[11:8];
      3'd3:    nib = bcd_q[15:12];
      3'd4:    nib = bcd_q[19:16];
      default: nib = 4'd0;
    endcase
  end

  always_comb begin
    seg_ah = 7'h00;
    if (digit_q == 3'd5) seg_ah = bcd_neg ? 7'h40 : 7'h00;
    else if (digit_q <= msd) seg_ah = seg_enc(nib);
    an_ah = 6'b000001 << digit_q;
  end

  assign seg_out = SEG_ACTIVE_LOW ? ~seg_ah : seg_ah;
  assign an_out  = SEG_ACTIVE_LOW ? ~an_ah  : an_ah;

endmodule

// File: tb/tb_bcd_display_driver.sv
// Directed bench for bcd_display_driver (SCAN_DIV=4, active-low pins).
// Signed-display vectors are exercised when SIGNED_DISPLAY_EN is defined.
module tb_bcd_display_driver;
  logic        clk = 1'b0;
  logic        RST;
  logic [15:0] value_in;
  logic        value_valid;
  logic        busy, bcd_valid, bcd_neg;
  logic [19:0] bcd_out;
  logic [6:0]  seg_out;
  logic [5:0]  an_out;

  int tests = 0;
  int fails = 0;
  int pulses = 0;
  int p0;
  int cnt;
  logic [19:0] held;

  bcd_display_driver #(.SCAN_DIV(4), .SEG_ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .RST(RST), .value_in(value_in), .value_valid(value_valid),
    .busy(busy), .bcd_out(bcd_out), .bcd_valid(bcd_valid), .bcd_neg(bcd_neg),
    .seg_out(seg_out), .an_out(an_out)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (bcd_valid === 1'b1) pulses <= pulses + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // wait (bounded) until digit d is selected, then check its active-high pattern
  task automatic show_digit(input int d, input logic [6:0] exp_ah, input string tag);
    logic [5:0] an_exp;
    logic [6:0] seg_exp;
    an_exp  = ~(6'b000001 << d);
    seg_exp = ~exp_ah;
    for (int i = 0; i < 40 && an_out !== an_exp; i++) @(negedge clk);
    chk({tag, "_an"}, an_out, an_exp);
    chk({tag, "_seg"}, seg_out, seg_exp);
  endtask

  task automatic start_conv(input logic [15:0] v);
    value_in    = v;
    value_valid = 1'b1;
    @(negedge clk);
    value_valid = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 60 && bcd_valid !== 1'b1; i++) @(negedge clk);
    chk({tag, "_valid"}, bcd_valid, 1);
  endtask

  initial begin
    RST = 1'b1;
    value_in = 16'd0;
    value_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_bcd", bcd_out, 20'h00000);
    chk("rst_busy", busy, 0);
    chk("rst_valid", bcd_valid, 0);
    chk("rst_neg", bcd_neg, 0);
    chk("rst_an", an_out, 6'b111110);
    chk("rst_seg", seg_out, 7'h40);
    RST = 1'b0;

    // prescaler wraps on the 4th edge after release
    repeat (3) @(negedge clk);
    chk("scan_pre_wrap_an", an_out, 6'b111110);
    @(negedge clk);
    chk("scan_wrap_an", an_out, 6'b111101);
    chk("scan_d1_blank", seg_out, 7'h7F);
    show_digit(5, 7'h00, "rst_d5");

    // 1234, single-cycle flag
    p0 = pulses;
    value_in = 16'd1234;
    value_valid = 1'b1;
    @(negedge clk);
    value_valid = 1'b0;
    cnt = 0;
    while (busy === 1'b1 && cnt < 40) begin
      cnt++;
      @(negedge clk);
    end
    chk("c1234_busy_len", cnt, 17);
    chk("c1234_valid", bcd_valid, 1);
    chk("c1234_bcd", bcd_out, 20'h01234);
    repeat (3) @(negedge clk);
    chk("c1234_pulses", pulses - p0, 1);
    show_digit(0, 7'h66, "c1234_d0");
    show_digit(1, 7'h4F, "c1234_d1");
    show_digit(2, 7'h5B, "c1234_d2");
    show_digit(3, 7'h06, "c1234_d3");
    show_digit(4, 7'h00, "c1234_d4");
    show_digit(5, 7'h00, "c1234_d5");

    // FFFF with level held: one conversion only
    p0 = pulses;
    value_in = 16'hFFFF;
    value_valid = 1'b1;
    repeat (50) @(negedge clk);
    value_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("cffff_pulses", pulses - p0, 1);
    chk("cffff_bcd", bcd_out, 20'h65535);
    chk("cffff_busy", busy, 0);
    show_digit(4, 7'h7D, "cffff_d4");
    show_digit(3, 7'h6D, "cffff_d3");
    show_digit(0, 7'h6D, "cffff_d0");

    // second edge while busy becomes a pending request
    p0 = pulses;
    value_in = 16'd16;
    value_valid = 1'b1;
    @(negedge clk);
    value_valid = 1'b0;
    repeat (4) @(negedge clk);
    value_in = 16'd32;
    value_valid = 1'b1;
    @(negedge clk);
    value_valid = 1'b0;
    chk("pend_busy", busy, 1);
    wait_valid("pend_first");
    chk("pend_first_bcd", bcd_out, 20'h00016);
    chk("pend_chain_busy", busy, 1);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (bcd_valid !== 1'b1 && cnt < 40);
    chk("pend_second_lat", cnt, 17);
    chk("pend_second_bcd", bcd_out, 20'h00032);
    held = bcd_out;
    repeat (8) @(negedge clk);
    chk("pend_pulses", pulses - p0, 2);
    chk("pend_hold", bcd_out, held);

    // reset mid-conversion
    p0 = pulses;
    start_conv(16'd999);
    repeat (7) @(negedge clk);
    chk("abort_busy_before", busy, 1);
    RST = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_bcd", bcd_out, 20'h00000);
    repeat (2) @(negedge clk);
    RST = 1'b0;
    repeat (25) @(negedge clk);
    chk("abort_pulses", pulses - p0, 0);
    chk("abort_bcd_after", bcd_out, 20'h00000);
    start_conv(16'd999);
    wait_valid("c999");
    chk("c999_bcd", bcd_out, 20'h00999);
    show_digit(2, 7'h6F, "c999_d2");
    show_digit(3, 7'h00, "c999_d3");

`ifdef SIGNED_DISPLAY_EN
    start_conv(16'hFFF6);
    wait_valid("neg10");
    chk("neg10_bcd", bcd_out, 20'h00010);
    chk("neg10_neg", bcd_neg, 1);
    show_digit(5, 7'h40, "neg10_d5");
    start_conv(16'h8000);
    wait_valid("neg32768");
    chk("neg32768_bcd", bcd_out, 20'h32768);
    chk("neg32768_neg", bcd_neg, 1);
    start_conv(16'd5);
    wait_valid("pos5");
    chk("pos5_bcd", bcd_out, 20'h00005);
    chk("pos5_neg", bcd_neg, 0);
    show_digit(5, 7'h00, "pos5_d5");
`else
    start_conv(16'hFFF6);
    wait_valid("uns_fff6");
    chk("uns_fff6_bcd", bcd_out, 20'h65526);
    chk("uns_fff6_neg", bcd_neg, 0);
    show_digit(5, 7'h00, "uns_fff6_d5");
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
